// File: rtl/wb_if.sv
// Wishbone B4 bus bundle (classic cycles plus CTI/BTE burst tags) shared by
// a single master and a single slave.
interface wb_if #(
    parameter int WB_ADDR_WIDTH = 32,
    parameter int WB_DATA_WIDTH = 32
);
    localparam int SEL_WIDTH = WB_DATA_WIDTH / 8;

    logic [WB_ADDR_WIDTH-1:0] adr;
    logic [2:0]               cti;
    logic [1:0]               bte;
    logic [WB_DATA_WIDTH-1:0] dat_w;
    logic [WB_DATA_WIDTH-1:0] dat_r;
    logic                     cyc;
    logic                     stb;
    logic [SEL_WIDTH-1:0]     sel;
    logic                     we;
    logic                     ack;
    logic                     err;

    modport master (
        output adr, cti, bte, dat_w, cyc, stb, sel, we,
        input  dat_r, ack, err
    );

    modport slave (
        input  adr, cti, bte, dat_w, cyc, stb, sel, we,
        output dat_r, ack, err
    );
endinterface

// File: rtl/wb_burst_sram.sv
// Wishbone slave SRAM with single and incrementing/wrapping burst support.
// Define WB_BURST_SRAM_ERR_EN to answer out-of-window requests with ERR.
module wb_burst_sram #(
    parameter int                       WB_ADDR_WIDTH  = 32,
    parameter int                       WB_DATA_WIDTH  = 32,
    parameter int                       MEM_DEPTH_LOG2 = 10,
    parameter logic [WB_ADDR_WIDTH-1:0] MEM_BASE       = '0
) (
    input logic clk,
    input logic rstn,
    wb_if.slave s
);
    localparam int         OB       = $clog2(WB_DATA_WIDTH / 8);
    localparam int         LANES    = WB_DATA_WIDTH / 8;
    localparam int         DEPTH    = 1 << MEM_DEPTH_LOG2;
    localparam logic [2:0] CTI_INCR = 3'b010;

    typedef enum logic [1:0] {IDLE, SINGLE, BURST, GAP} state_t;
    typedef logic [MEM_DEPTH_LOG2-1:0] idx_t;

    state_t                   state_q, state_d;
    idx_t                     addr_q, addr_d;
    logic                     ack_q, ack_d;
    logic [WB_DATA_WIDTH-1:0] dat_r_q, dat_r_d;
    logic [WB_DATA_WIDTH-1:0] mem [DEPTH];

    logic [WB_ADDR_WIDTH-1:0] offset;
    idx_t                     word_idx;
    idx_t                     wrap_mask;
    idx_t                     burst_next;
    logic                     req;
    logic                     ack;
    logic                     req_bad;

    assign offset   = s.adr - MEM_BASE;
    assign word_idx = idx_t'(offset >> OB);
    assign req      = s.cyc & s.stb;
    assign ack      = ack_q & req;
    assign s.ack    = ack;

`ifdef WB_BURST_SRAM_ERR_EN
    logic                   err_q, err_d;
    logic [WB_ADDR_WIDTH:0] diff_ext;

    // The extra top bit is the borrow, i.e. the address lies below the window.
    assign diff_ext = {1'b0, s.adr} - {1'b0, MEM_BASE};
    assign req_bad  = diff_ext[WB_ADDR_WIDTH] ||
                      ((diff_ext[WB_ADDR_WIDTH-1:0] >> (MEM_DEPTH_LOG2 + OB)) != '0);
    assign s.err    = err_q & req;
`else
    assign req_bad  = 1'b0;
    assign s.err    = 1'b0;
`endif

    // Wrapping bursts only let the low bits of the word index roll over.
    always_comb begin
        case (s.bte)
            2'b01:   wrap_mask = idx_t'(4'h3);
            2'b10:   wrap_mask = idx_t'(4'h7);
            2'b11:   wrap_mask = idx_t'(4'hF);
            default: wrap_mask = '1;
        endcase
    end

    assign burst_next = (addr_q & ~wrap_mask) | ((addr_q + idx_t'(1)) & wrap_mask);

    always_comb begin
        // NOTE: every target is given a default first, so no path can infer a latch.
        state_d = state_q;
        addr_d  = addr_q;
        ack_d   = 1'b0;
`ifdef WB_BURST_SRAM_ERR_EN
        err_d   = 1'b0;
`endif
        if (!s.cyc) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (s.stb) begin
                        addr_d  = word_idx;
                        state_d = (s.cti == CTI_INCR && !req_bad) ? BURST : SINGLE;
                        ack_d   = !req_bad;
`ifdef WB_BURST_SRAM_ERR_EN
                        err_d   = req_bad;
`endif
                    end
                end
                SINGLE: state_d = GAP;
                BURST: begin
                    ack_d = 1'b1;
                    if (ack) begin
                        addr_d = burst_next;
                        if (s.cti != CTI_INCR) begin
                            state_d = GAP;
                            ack_d   = 1'b0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Read data is combinational during the ACK cycle and held afterwards.
    always_comb begin
        dat_r_d = dat_r_q;
        if (ack && !s.we) begin
            dat_r_d = mem[addr_q];
        end
    end

    assign s.dat_r = dat_r_d;

    // NOTE: state flops use non-blocking assignments so all of them sample pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            addr_q  <= '0;
            ack_q   <= 1'b0;
            dat_r_q <= '0;
`ifdef WB_BURST_SRAM_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            ack_q   <= ack_d;
            dat_r_q <= dat_r_d;
`ifdef WB_BURST_SRAM_ERR_EN
            err_q   <= err_d;
`endif
        end
    end

    // NOTE: the storage array has no reset; its contents are undefined after rstn.
    always_ff @(posedge clk) begin
        if (ack && s.we) begin
            for (int i = 0; i < LANES; i++) begin
                if (s.sel[i]) begin
                    mem[addr_q][i*8 +: 8] <= s.dat_w[i*8 +: 8];
                end
            end
        end
    end
endmodule

// File: doc/wb_burst_sram.md
WB_BURST_SRAM -- requirements
Module: wb_burst_sram

Interface
REQ-001 SHALL have parameter WB_ADDR_WIDTH, default 32, meaning Wishbone byte-address width.
REQ-002 SHALL have parameter WB_DATA_WIDTH, default 32, meaning data width (multiple of 8); byte-lane bits OB = log2(WB_DATA_WIDTH/8).
REQ-003 SHALL have parameter MEM_DEPTH_LOG2, default 10, meaning log2 of the number of words stored.
REQ-004 SHALL have parameter MEM_BASE, default 'h0, meaning byte base address of the memory window.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all state is on its rising edge.
REQ-006 SHALL have port rstn, input, 1, meaning asynchronous active-low reset.
REQ-007 SHALL have port s, wb_if.slave, WB_ADDR_WIDTH/WB_DATA_WIDTH, meaning the Wishbone slave port driven by one interconnect slave port (ADR, CTI[2:0], BTE[1:0], DAT_W, DAT_R, CYC, STB, SEL, WE, ACK, ERR).

Function
REQ-008 SHALL keep an FSM with states IDLE, SINGLE, BURST, GAP.
REQ-009 SHALL have offset = ADR - MEM_BASE and word index = offset[MEM_DEPTH_LOG2+OB-1:OB].
REQ-010 IDLE with CYC&STB high SHALL latch the word index into addr_q and SHALL go to BURST if CTI==3'b010, else to SINGLE.
REQ-011 SHALL generate ACK = ack_q & CYC & STB, where ack_q is high in SINGLE and BURST; the first ACK therefore appears exactly one cycle after the request.
REQ-012 SINGLE SHALL last one cycle, then go to GAP; GAP SHALL last one cycle with ack_q low, then go to IDLE.
REQ-013 A beat is accepted when ACK is high; on an accepted write beat, each byte lane i of mem[addr_q] with SEL[i]=1 SHALL be updated from DAT_W, and lanes with SEL[i]=0 SHALL be left unchanged.
REQ-014 On an accepted read beat, DAT_R SHALL equal mem[addr_q], so read data is valid in the same cycle ACK is high; DAT_R SHALL hold its last value otherwise.
REQ-015 In BURST, each accepted beat SHALL advance addr_q: by BTE 00 linearly +1, wrapping at 2^MEM_DEPTH_LOG2; by BTE 01, 10 or 11, +1 within an aligned 4-, 8- or 16-word block, where only the low 2, 3 or 4 bits change.
REQ-016 BURST SHALL assert ACK on every consecutive cycle while STB is high; a cycle with STB low SHALL be a wait state with no ACK, no write and addr_q held.
REQ-017 An accepted beat with CTI==3'b111 SHALL end the burst and go to GAP; an accepted beat with CTI other than 3'b010 SHALL likewise end the burst.
REQ-018 CYC low in any state SHALL force IDLE on the next edge with ack_q low; the current cycle SHALL produce no ACK and no write.
REQ-019 ERR SHALL be 0 whenever the error feature of REQ-023 is not compiled in.
REQ-020 ACK and ERR SHALL never be high in the same cycle.

Reset
REQ-021 Asserting rstn low SHALL immediately force: state IDLE, ack_q 0, addr_q 0, DAT_R 0, ACK 0, ERR 0; memory contents are undefined after reset.
REQ-022 Reset asserted mid-burst SHALL abort the burst with no further ACK; the first request after rstn deasserts SHALL be serviced as in REQ-010.

Configuration
REQ-023 With macro WB_BURST_SRAM_ERR_EN defined: a request whose offset is >= 2^(MEM_DEPTH_LOG2+OB), or whose ADR is below MEM_BASE, SHALL get ERR (not ACK) one cycle later for one cycle, then GAP; no write SHALL occur and the burst SHALL terminate.
REQ-024 Without WB_BURST_SRAM_ERR_EN: ERR SHALL be tied to 0, and out-of-window addresses SHALL alias using only the word-index bits.

Verification
REQ-025 Single write ADR=MEM_BASE+'h10, DAT_W='hDEADBEEF, SEL='hF, CTI=000 -> ACK in cycle 2 only, ACK low in cycle 3; a read of 'h10 returns 'hDEADBEEF.
REQ-026 Partial write SEL=4'b0010 with DAT_W='h0000AB00 over 'h11223344 -> a read returns 'h1122AB44.
REQ-027 Incrementing read burst, BTE=01, start word 6, 4 beats with CTI=010,010,010,111 -> ACK on 4 consecutive cycles, word indices 6,7,4,5, then ACK low.
REQ-028 Linear burst starting at word 2^MEM_DEPTH_LOG2-1, 2 beats -> indices 1023 then 0 at the default depth; STB low for 2 cycles mid-burst -> no ACK in those cycles, index held.
REQ-029 CYC dropped mid-burst, then rstn pulsed low mid-burst -> ACK deasserts with no spurious write; the next single read is ACKed after 1 cycle.
REQ-030 With WB_BURST_SRAM_ERR_EN defined, ADR=MEM_BASE+(4<<MEM_DEPTH_LOG2) -> ERR for 1 cycle, no ACK, memory unchanged; without the macro, the same access writes word 0.
